// File: rtl/frodo_sram_pkg.sv
// Shared constants, FSM state type and address helper for the
// 320x36 SRAM stream read sequencer.
package frodo_sram_pkg;

  localparam int unsigned N           = 36;
  localparam int unsigned M           = 9;
  localparam int unsigned DEPTH_WORDS = 320;
  localparam int unsigned FIFO_DEPTH  = 3;
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Sequential SRAM address with wrap at the last valid word
  function automatic logic [M-1:0] addr_next(input logic [M-1:0] a);
    return (a == M'(DEPTH_WORDS - 1)) ? '0 : a + M'(1);
  endfunction

endpackage

// File: rtl/spsram_rd_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and an
// occupancy count; simultaneous push and pop keeps the count unchanged.
module spsram_rd_fifo #(
  parameter int unsigned W     = 36,
  parameter int unsigned DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_data,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/spsram_stream_rd.sv
// Read-side sequencer for the 320x36 single-port SRAM: issues sequential
// reads, absorbs the 1-cycle read latency and streams words out.
module spsram_stream_rd
  import frodo_sram_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] base_addr,
  input  logic [M:0]   len,
  output logic         busy,
  output logic         done,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N-1:0] m_data,
  output logic         mem_en,
  output logic         mem_we,
  output logic [M-1:0] mem_addr,
  input  logic [N-1:0] mem_dout
);

  localparam int unsigned LEN_W = M + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [LEN_W-1:0] r_rem;
  logic [LEN_W-1:0] w_rem_nxt;
  logic [M-1:0]     r_addr;
  logic [M-1:0]     w_addr_nxt;
  logic             r_mem_en;
  logic             w_mem_en_nxt;
  logic             r_inflight;
  logic             w_infl_nxt;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] w_count;
  logic [OCC_W-1:0] w_occ_nxt;
  logic [N-1:0]     w_fifo_data;
  logic             w_pop;
  logic [M-1:0]     w_base_c;
  logic [LEN_W-1:0] w_len_c;

  spsram_rd_fifo #(
    .W     (N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (mem_dout),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_count)
  );

  assign m_valid  = (w_count != '0);
  assign m_data   = w_fifo_data;
  assign w_pop    = m_valid && m_ready;
  assign mem_en   = r_mem_en;
  assign mem_we   = 1'b0;
  assign mem_addr = r_addr;
  assign busy     = r_busy;
  assign done     = r_done;

  assign w_base_c = (base_addr >= M'(DEPTH_WORDS)) ? '0 : base_addr;
  assign w_len_c  = (len > LEN_W'(DEPTH_WORDS)) ? LEN_W'(DEPTH_WORDS) : len;

  // Next-cycle occupancy/inflight let mem_en be registered yet obey the issue rule
  assign w_infl_nxt = r_mem_en;
  assign w_occ_nxt  = {1'b0, w_count} + OCC_W'(r_inflight) - OCC_W'(w_pop);

  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_mem_en ? r_rem - LEN_W'(1) : r_rem;
    w_addr_nxt   = r_mem_en ? addr_next(r_addr) : r_addr;
    w_mem_en_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_rem_nxt   = w_len_c;
          w_addr_nxt  = w_base_c;
          w_state_nxt = (w_len_c == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_rem_nxt == '0) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((w_occ_nxt == '0) && !w_infl_nxt) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_mem_en_nxt = (w_state_nxt == RUN) && (w_rem_nxt != '0) &&
                   ((w_occ_nxt + OCC_W'(w_infl_nxt)) < OCC_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rem      <= '0;
      r_addr     <= '0;
      r_mem_en   <= 1'b0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rem      <= w_rem_nxt;
      r_addr     <= w_addr_nxt;
      r_mem_en   <= w_mem_en_nxt;
      r_inflight <= w_infl_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= (w_state_nxt == DONE);
    end
  end

endmodule
